// File: rtl/pet2001_dma_ctrl.sv
// ---------------------------------------------------------------------------
// pet2001_dma_ctrl
//
// Owns the second port of main RAM and shares it between two requesters:
//   - a PRG loader that streams {addr_lo, addr_hi, payload...} bytes, which
//     are written into RAM starting at the header address;
//   - a single-byte debug/snapshot reader.
// The CPU is held (cpu_hold) for the whole load session.
//
// Optional feature macro: PET_PRG_FIXUP_EN
//   When defined, a FIX state follows every load and writes the end-of-load
//   address into the BASIC pointer triple VARTAB/ARYTAB/STREND at
//   VARTAB_ADDR..VARTAB_ADDR+5 (three little-endian 16-bit words).
//   When undefined, DATA goes straight to DONE and nothing outside the
//   payload range is written.
//
// Parameters
//   RAM_SIZE     bytes reachable on the port; load addresses >= RAM_SIZE are
//                dropped and flag err
//   VARTAB_ADDR  base of the BASIC pointer triple (fix-up builds only)
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   ld_valid   loader byte valid
//   ld_data    loader byte
//   ld_last    marks the final byte of the PRG stream
//   ld_ready   loader byte accepted when ld_valid & ld_ready
//   rd_req     read request level, held until rd_ack
//   rd_addr    read address, stable while rd_req is high
//   rd_ack     one-cycle pulse, rd_data valid in the same cycle
//   rd_data    captured read data, held until the next rd_ack
//   dma_addr   RAM port address
//   dma_din    RAM port write data
//   dma_we     RAM port write strobe
//   dma_dout   RAM port read data, valid one clock after the address
//   cpu_hold   high while a load session is open
//   busy       loader FSM is not idle
//   err        sticky per session: out-of-range byte or truncated header
// ---------------------------------------------------------------------------
module pet2001_dma_ctrl #(
`ifdef PET_PRG_FIXUP_EN
   parameter logic [13:0] VARTAB_ADDR = 14'h002A,
`endif
   parameter logic [16:0] RAM_SIZE    = 17'h04000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   input  logic [7:0]  ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   input  logic        rd_req,
   input  logic [13:0] rd_addr,
   output logic        rd_ack,
   output logic [7:0]  rd_data,
   output logic [13:0] dma_addr,
   output logic [7:0]  dma_din,
   output logic        dma_we,
   input  logic [7:0]  dma_dout,
   output logic        cpu_hold,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_HI = 3'd1,
      DATA   = 3'd2,
      FIX    = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t      state;
   logic [7:0]  addr_lo;
   logic [15:0] ptr;
   logic [3:0]  burst_cnt;
   logic        rd_inflight;
`ifdef PET_PRG_FIXUP_EN
   logic [15:0] end_ptr;
   logic [2:0]  fix_cnt;
`endif

   logic port_open;
   logic throttle;
   logic ld_open;
   logic rd_issue;
   logic accept;
   logic in_range;

   // Port arbitration. The loader wins whenever it has a byte to hand over,
   // so a read can only be decided in a cycle where no byte is accepted;
   // that keeps the following cycle free of a write and lets the read own
   // the port there. While a read waits, the loader is forced to skip one
   // cycle after every 8 back-to-back accepts so the read cannot starve.
   // A read is not re-decided while one is in flight or being acknowledged,
   // so a requester that still holds rd_req in the ack cycle gets no extra
   // read.
   always_comb begin
      port_open = 1'b0;
      throttle  = 1'b0;
      ld_open   = 1'b0;
      rd_issue  = 1'b0;
      ld_ready  = 1'b0;
      accept    = 1'b0;
      in_range  = 1'b0;

      port_open = !reset && ((state == IDLE) || (state == HDR_HI) || (state == DATA));
      throttle  = (burst_cnt == 4'd8);
      ld_open   = port_open && !throttle;
      rd_issue  = port_open && rd_req && !rd_inflight && !rd_ack && !(ld_valid && ld_open);
      ld_ready  = ld_open && !rd_issue;
      accept    = ld_valid && ld_ready;
      in_range  = ({1'b0, ptr} < RAM_SIZE);
   end

   assign busy = (state != IDLE);

   // Main sequential block: loader FSM, registered RAM port and read path.
   // Writes and reads are registered, so dma_we/dma_addr appear on the clock
   // after the decision. The read data is combinationally valid while the
   // read address sits on the port, and is captured at the end of that
   // cycle together with the rd_ack pulse. The load pointer is 16 bits wide
   // and wraps from FFFF to 0000; the range test is made on the full 16-bit
   // value, so bytes beyond RAM never alias into low RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         addr_lo     <= 8'h00;
         ptr         <= 16'h0000;
         burst_cnt   <= 4'd0;
         rd_inflight <= 1'b0;
         rd_ack      <= 1'b0;
         rd_data     <= 8'h00;
         dma_addr    <= 14'h0000;
         dma_din     <= 8'h00;
         dma_we      <= 1'b0;
         cpu_hold    <= 1'b0;
         err         <= 1'b0;
`ifdef PET_PRG_FIXUP_EN
         end_ptr     <= 16'h0000;
         fix_cnt     <= 3'd0;
`endif
      end else begin
         dma_we      <= 1'b0;
         rd_ack      <= 1'b0;
         rd_inflight <= rd_issue;

         if (rd_inflight) begin
            rd_data <= dma_dout;
            rd_ack  <= 1'b1;
         end

         if (rd_issue) begin
            dma_addr <= rd_addr;
         end

         if (accept && rd_req) begin
            burst_cnt <= burst_cnt + 4'd1;
         end else begin
            burst_cnt <= 4'd0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  addr_lo <= ld_data;
                  if (ld_last) begin
                     err <= 1'b1;
                  end else begin
                     err      <= 1'b0;
                     cpu_hold <= 1'b1;
                     state    <= HDR_HI;
                  end
               end
            end

            HDR_HI: begin
               if (accept) begin
                  ptr <= {ld_data, addr_lo};
                  if (ld_last) begin
                     err      <= 1'b1;
                     cpu_hold <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               if (accept) begin
                  if (in_range) begin
                     dma_we   <= 1'b1;
                     dma_addr <= ptr[13:0];
                     dma_din  <= ld_data;
                  end else begin
                     err <= 1'b1;
                  end
                  ptr <= ptr + 16'd1;
                  if (ld_last) begin
`ifdef PET_PRG_FIXUP_EN
                     end_ptr <= ptr + 16'd1;
                     fix_cnt <= 3'd0;
                     state   <= FIX;
`else
                     state   <= DONE;
`endif
                  end
               end
            end

`ifdef PET_PRG_FIXUP_EN
            FIX: begin
               dma_we   <= 1'b1;
               dma_addr <= VARTAB_ADDR + {11'd0, fix_cnt};
               dma_din  <= fix_cnt[0] ? end_ptr[15:8] : end_ptr[7:0];
               fix_cnt  <= fix_cnt + 3'd1;
               if (fix_cnt == 3'd5) begin
                  state <= DONE;
               end
            end
`endif

            DONE: begin
               cpu_hold <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pet2001_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pet2001_dma_ctrl
//
// Directed bench for pet2001_dma_ctrl. A behavioural RAM with asynchronous
// read sits on the DMA port and counts every write strobe. Stimulus is one
// linear sequence; every comparison goes through checkOutput.
// Honours PET_PRG_FIXUP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pet2001_dma_ctrl;

`ifdef PET_PRG_FIXUP_EN
   localparam int FIXLEN = 6;
`else
   localparam int FIXLEN = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        rd_req;
   logic [13:0] rd_addr;
   logic        rd_ack;
   logic [7:0]  rd_data;
   logic [13:0] dma_addr;
   logic [7:0]  dma_din;
   logic        dma_we;
   logic [7:0]  dma_dout;
   logic        cpu_hold;
   logic        busy;
   logic        err;

   logic [7:0]  mem [0:16383];
   int          wr_cnt = 0;

   int          total = 0;
   int          bad   = 0;
   int          base;
   logic        ack_ok;
   logic [7:0]  ack_data;
   int          ack_wait;

   pet2001_dma_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_ready (ld_ready),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_ack   (rd_ack),
      .rd_data  (rd_data),
      .dma_addr (dma_addr),
      .dma_din  (dma_din),
      .dma_we   (dma_we),
      .dma_dout (dma_dout),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .err      (err)
   );

   // 100 MHz style free-running clock.
   always #5 clk = ~clk;

   // Behavioural RAM: synchronous write, read data follows the address
   // within the cycle so it is valid by the next clock edge. Every strobe
   // is counted so stray or missing writes show up in the totals.
   always @(posedge clk) begin
      if (dma_we) begin
         mem[dma_addr] <= dma_din;
         wr_cnt        <= wr_cnt + 1;
      end
   end

   assign dma_dout = mem[dma_addr];

   // Single comparison point: counts it, and reports tag/observed/expected
   // when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one loader byte at a negedge and holds it until it is taken,
   // returning on the negedge after the accepting clock edge. A byte that
   // is never taken within the bound is reported as a failed accept.
   task automatic applyStimulus(input logic [7:0] b, input logic last);
      logic got;
      got      = 1'b0;
      ld_valid = 1'b1;
      ld_data  = b;
      ld_last  = last;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (ld_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      checkOutput("ld_accept", {31'd0, got}, 32'd1);
   endtask

   // Linear directed sequence.
   initial begin
      reset    = 1'b1;
      ld_valid = 1'b0;
      ld_data  = 8'h00;
      ld_last  = 1'b0;
      rd_req   = 1'b0;
      rd_addr  = 14'h0000;
      repeat (2) @(negedge clk);

      checkOutput("rst_ld_ready", ld_ready, 0);
      checkOutput("rst_rd_ack",   rd_ack,   0);
      checkOutput("rst_rd_data",  rd_data,  0);
      checkOutput("rst_dma_we",   dma_we,   0);
      checkOutput("rst_dma_addr", dma_addr, 0);
      checkOutput("rst_dma_din",  dma_din,  0);
      checkOutput("rst_cpu_hold", cpu_hold, 0);
      checkOutput("rst_busy",     busy,     0);
      checkOutput("rst_err",      err,      0);

      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_ld_ready", ld_ready, 1);

      $display("[TB] truncated headers");
      base = wr_cnt;
      applyStimulus(8'h10, 1'b1);
      checkOutput("hdr1_err",      err,      1);
      checkOutput("hdr1_cpu_hold", cpu_hold, 0);
      checkOutput("hdr1_busy",     busy,     0);
      checkOutput("hdr1_dma_we",   dma_we,   0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("hdr2_err_clear", err,      0);
      checkOutput("hdr2_cpu_hold",  cpu_hold, 1);
      applyStimulus(8'h20, 1'b1);
      checkOutput("hdr2_err",      err,      1);
      checkOutput("hdr2_cpu_hold", cpu_hold, 0);
      checkOutput("hdr2_busy",     busy,     0);
      checkOutput("hdr_no_writes", wr_cnt - base, 0);

      $display("[TB] basic load 0401");
      base = wr_cnt;
      applyStimulus(8'h01, 1'b0);
      checkOutput("t1_err_clear", err,      0);
      checkOutput("t1_cpu_hold",  cpu_hold, 1);
      checkOutput("t1_busy",      busy,     1);
      applyStimulus(8'h04, 1'b0);
      applyStimulus(8'hAA, 1'b0);
      checkOutput("t1_we",   dma_we,   1);
      checkOutput("t1_addr", dma_addr, 14'h0401);
      checkOutput("t1_din",  dma_din,  8'hAA);
      applyStimulus(8'hBB, 1'b0);
      applyStimulus(8'hCC, 1'b1);
      repeat (FIXLEN) @(negedge clk);
      checkOutput("t1_hold_to_done", cpu_hold, 1);
      @(negedge clk);
      checkOutput("t1_hold_release", cpu_hold, 0);
      checkOutput("t1_idle",         busy,     0);
      checkOutput("t1_err",          err,      0);
      checkOutput("t1_wr_cnt",       wr_cnt - base, 3 + FIXLEN);
      checkOutput("t1_m0401", mem[14'h0401], 8'hAA);
      checkOutput("t1_m0402", mem[14'h0402], 8'hBB);
      checkOutput("t1_m0403", mem[14'h0403], 8'hCC);
`ifdef PET_PRG_FIXUP_EN
      for (int i = 0; i < 6; i++) begin
         checkOutput("t1_fixup", mem[14'h002A + i], 8'h04);
      end
`endif

      $display("[TB] idle read of 0123");
      applyStimulus(8'h23, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h5A, 1'b1);
      repeat (FIXLEN + 1) @(negedge clk);
      checkOutput("rd_pre_idle", busy, 0);
      rd_addr = 14'h0123;
      rd_req  = 1'b1;
      @(negedge clk);
      checkOutput("rd_issue_addr", dma_addr, 14'h0123);
      checkOutput("rd_issue_we",   dma_we,   0);
      checkOutput("rd_issue_ack",  rd_ack,   0);
      @(negedge clk);
      checkOutput("rd_ack",  rd_ack,  1);
      checkOutput("rd_data", rd_data, 8'h5A);
      rd_req = 1'b0;
      @(negedge clk);
      checkOutput("rd_ack_pulse", rd_ack,  0);
      checkOutput("rd_data_hold", rd_data, 8'h5A);

      $display("[TB] pointer wrap FFFE");
      base = wr_cnt;
      applyStimulus(8'hFE, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h03, 1'b0);
      applyStimulus(8'h04, 1'b1);
      repeat (FIXLEN + 1) @(negedge clk);
      checkOutput("wrap_err",    err,    1);
      checkOutput("wrap_idle",   busy,   0);
      checkOutput("wrap_wr_cnt", wr_cnt - base, 2 + FIXLEN);
      checkOutput("wrap_m0000",  mem[14'h0000], 8'h03);
      checkOutput("wrap_m0001",  mem[14'h0001], 8'h04);
`ifdef PET_PRG_FIXUP_EN
      checkOutput("wrap_fix_lo", mem[14'h002A], 8'h02);
      checkOutput("wrap_fix_hi", mem[14'h002B], 8'h00);
`endif

      $display("[TB] load crossing top of RAM");
      base = wr_cnt;
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h3F, 1'b0);
      for (int i = 0; i < 16'h0200; i++) begin
         applyStimulus(8'(i) ^ 8'hA5, (i == 16'h01FF));
      end
      repeat (FIXLEN + 1) @(negedge clk);
      checkOutput("top_err",    err,    1);
      checkOutput("top_idle",   busy,   0);
      checkOutput("top_wr_cnt", wr_cnt - base, 16'h0100 + FIXLEN);
      checkOutput("top_m3F00",  mem[14'h3F00], 8'hA5);
      checkOutput("top_m3F7F",  mem[14'h3F7F], 8'hDA);
      checkOutput("top_m3FFF",  mem[14'h3FFF], 8'h5A);
      checkOutput("top_no_alias", mem[14'h0000], 8'h03);
`ifdef PET_PRG_FIXUP_EN
      checkOutput("top_fix_lo",  mem[14'h002A], 8'h00);
      checkOutput("top_fix_hi",  mem[14'h002B], 8'h41);
      checkOutput("top_fix_shi", mem[14'h002F], 8'h41);
`endif

      $display("[TB] read during continuous stream");
      base     = wr_cnt;
      ack_ok   = 1'b0;
      ack_data = 8'h00;
      ack_wait = 0;
      fork
         begin
            applyStimulus(8'h00, 1'b0);
            applyStimulus(8'h10, 1'b0);
            for (int i = 0; i < 24; i++) begin
               applyStimulus(8'h60 + 8'(i), (i == 23));
            end
         end
         begin
            repeat (4) @(negedge clk);
            rd_addr = 14'h0401;
            rd_req  = 1'b1;
            for (int n = 1; n <= 14; n++) begin
               @(negedge clk);
               if (rd_ack) begin
                  ack_ok   = 1'b1;
                  ack_data = rd_data;
                  ack_wait = n;
                  break;
               end
            end
            rd_req = 1'b0;
         end
      join
      checkOutput("mix_ack_seen", ack_ok, 1);
      checkOutput("mix_ack_in_time", (ack_wait >= 1 && ack_wait <= 10), 1);
      checkOutput("mix_rd_data", ack_data, 8'hAA);
      for (int k = 0; k < 20 && busy; k++) @(negedge clk);
      checkOutput("mix_idle", busy, 0);
      checkOutput("mix_err",  err,  0);
      checkOutput("mix_wr_cnt", wr_cnt - base, 24 + FIXLEN);
      for (int i = 0; i < 24; i++) begin
         checkOutput("mix_image", mem[14'h1000 + i], 8'h60 + 8'(i));
      end

      $display("[TB] reset in the middle of DATA");
      base = wr_cnt;
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mr_ld_ready", ld_ready, 0);
      checkOutput("mr_rd_ack",   rd_ack,   0);
      checkOutput("mr_rd_data",  rd_data,  0);
      checkOutput("mr_dma_we",   dma_we,   0);
      checkOutput("mr_dma_addr", dma_addr, 0);
      checkOutput("mr_dma_din",  dma_din,  0);
      checkOutput("mr_cpu_hold", cpu_hold, 0);
      checkOutput("mr_busy",     busy,     0);
      checkOutput("mr_err",      err,      0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mr_wr_cnt", wr_cnt - base, 3);
      checkOutput("mr_m0500",  mem[14'h0500], 8'h11);
      checkOutput("mr_m0501",  mem[14'h0501], 8'h22);
      checkOutput("mr_m0502",  mem[14'h0502], 8'h33);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h06, 1'b0);
      applyStimulus(8'h44, 1'b0);
      applyStimulus(8'h55, 1'b1);
      repeat (FIXLEN + 1) @(negedge clk);
      checkOutput("mr_next_idle", busy, 0);
      checkOutput("mr_next_err",  err,  0);
      checkOutput("mr_m0600",     mem[14'h0600], 8'h44);
      checkOutput("mr_m0601",     mem[14'h0601], 8'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
